sequenciador_operandos: RTL and testbench
=========================================

# sequenciador_operandos

Upstream feeder for the shift-add `Multiplicador` (4-bit operands, `st`/`done`/`idle`, 9-bit `produto`). It buffers operand pairs in a small FIFO and issues one `st` pulse per pair. It then waits for `done` and captures the product. Each result is presented on a valid/ready output with a timeout error flag.

## Interface
- `PROF_FIFO`, 4: operand FIFO depth (power of 2, ≥2)
- `TIMEOUT`, 32: max cycles in ESPERA before error (≥8)
- `LARG_ACUM`, 16: accumulator width (used only with macro)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `ent_valido`  in  1  operand pair valid
- `ent_pronto`  out  1  FIFO can accept (= not full; 0 while `rst`)
- `ent_multiplicando`  in  4  operand A
- `ent_multiplicador`  in  4  operand B
- `mult_multiplicando`  out  4  to multiplier, held stable INICIA..ESPERA
- `mult_multiplicador`  out  4  to multiplier, held stable INICIA..ESPERA
- `mult_st`  out  1  start, one-cycle pulse
- `mult_done`  in  1  multiplier done
- `mult_idle`  in  1  multiplier idle
- `mult_produto`  in  9  multiplier product
- `sai_valido`  out  1  result valid
- `sai_pronto`  in  1  downstream accepts
- `sai_produto`  out  9  captured product
- `sai_erro`  out  1  result is a timeout (qualified by `sai_valido`)
- `ocupacao`  out  clog2(PROF_FIFO)+1  FIFO entry count
- `acumulado`  out  LARG_ACUM  running sum (macro only, else 0)

## Operation
- FIFO push when `ent_valido && ent_pronto`. Pop happens only in OCIOSO when FIFO is non-empty and `mult_idle=1`. Push and pop in the same cycle are allowed: `ocupacao` is unchanged. No push when full, no pop when empty.
- FSM states: OCIOSO, INICIA, ESPERA, ENTREGA.
  - OCIOSO: on pop, load operand registers, go to INICIA.
  - INICIA: `mult_st=1` for exactly this cycle, clear timeout counter, go to ESPERA.
  - ESPERA: counter increments each cycle.
    - `mult_done=1`: capture `mult_produto`, `sai_erro=0`, go to ENTREGA.
    - Counter reaches `TIMEOUT-1` without done: `sai_produto=0`, `sai_erro=1`, go to ENTREGA.
    - Done wins if both occur in the same cycle.
  - ENTREGA: `sai_valido=1`. `sai_produto`/`sai_erro` are stable until `sai_pronto=1`, then go to OCIOSO. The FIFO keeps accepting meanwhile.
- `mult_done` outside ESPERA is ignored.
- Only one operation is ever in flight.

## Timing
- Reset values:
  - state OCIOSO; FIFO empty, `ocupacao=0`.
  - `mult_st=0`, `mult_*` operands 0.
  - `sai_valido=0`, `sai_produto=0`, `sai_erro=0`, `acumulado=0`.
  - `ent_pronto=0` during `rst`, 1 on the first cycle after.
- Push at edge N into an empty FIFO with `mult_idle=1` gives `mult_st=1` in cycle N+2.
- `mult_done` seen at edge D gives `sai_valido=1` from D+1.
- Handshake completes at edge E (`sai_valido && sai_pronto`). The earliest next `mult_st` is E+2.
- `rst` mid-operation:
  - FIFO contents and in-flight result are discarded.
  - The multiplier has no reset, so after `rst` no `st` is issued until `mult_idle=1`.
- Full FIFO: `ent_pronto=0` combinationally when `ocupacao==PROF_FIFO`. A pop in the same cycle does not raise `ent_pronto` until the next cycle.
- FIFO pointers wrap modulo `PROF_FIFO`.

## Configuration
- `SEQUENCIADOR_ACUMULADOR_EN` defined:
  - `acumulado` adds `sai_produto` (zero-extended) on each accepted non-error result.
  - It saturates at 2^LARG_ACUM−1 and is cleared only by `rst`.
- Undefined: no accumulator logic, `acumulado` tied to 0, port retained.

## Test plan
- Push (13,11) with the real `Multiplicador` and `sai_pronto=1`: exactly one `mult_st` pulse, then `sai_valido=1`, `sai_produto=143`, `sai_erro=0`.
- Push (13,11),(7,15),(15,15),(0,9) back-to-back with `sai_pronto=0` for 100 cycles:
  - `ent_pronto` drops only when `ocupacao=4`.
  - Results then come out in order 143, 105, 225, 0.
  - Each result is held until `sai_pronto`.
- Stub multiplier that never asserts done: `sai_valido=1` exactly `TIMEOUT` cycles after `mult_st`, with `sai_erro=1` and `sai_produto=0`. The next pair then proceeds normally.
- Assert `rst` during ESPERA while the stub holds `mult_idle=0` for 10 more cycles:
  - All outputs return to reset values.
  - A new push yields no `mult_st` until `mult_idle=1`.
- With macro, `LARG_ACUM=8`: results 143 then 105 give `acumulado=248`. A further 15×15 saturates it at 255. The same sequence with a timeout in between leaves `acumulado` unchanged by the error result.

Source files
------------

// File: rtl/sequenciador_operandos_if.sv
// sequenciador_operandos_if
// Groups the three handshakes of the operand sequencer into one bundle:
//   ent_*  : operand pair input (valid/ready), 4-bit multiplicand/multiplier
//   mult_* : link to the shift-add multiplier (st/done/idle, operands, 9-bit product)
//   sai_*  : result output (valid/ready), 9-bit product plus timeout error flag
// Modports:
//   master : the sequencer itself (drives ent_pronto, mult_st, mult operands, sai_*)
//   slave  : the environment (upstream source, multiplier, downstream sink)
interface sequenciador_operandos_if;
    logic       ent_valido;
    logic       ent_pronto;
    logic [3:0] ent_multiplicando;
    logic [3:0] ent_multiplicador;

    logic [3:0] mult_multiplicando;
    logic [3:0] mult_multiplicador;
    logic       mult_st;
    logic       mult_done;
    logic       mult_idle;
    logic [8:0] mult_produto;

    logic       sai_valido;
    logic       sai_pronto;
    logic [8:0] sai_produto;
    logic       sai_erro;

    modport master (
        input  ent_valido, ent_multiplicando, ent_multiplicador,
        input  mult_done, mult_idle, mult_produto,
        input  sai_pronto,
        output ent_pronto,
        output mult_multiplicando, mult_multiplicador, mult_st,
        output sai_valido, sai_produto, sai_erro
    );

    modport slave (
        output ent_valido, ent_multiplicando, ent_multiplicador,
        output mult_done, mult_idle, mult_produto,
        output sai_pronto,
        input  ent_pronto,
        input  mult_multiplicando, mult_multiplicador, mult_st,
        input  sai_valido, sai_produto, sai_erro
    );
endinterface

// File: rtl/sequenciador_operandos.sv
// sequenciador_operandos
// Upstream feeder for the shift-add multiplier. Operand pairs are buffered in a
// small FIFO; one pair at a time is issued with a single-cycle st pulse, the
// product is captured on done (or replaced by an error result on timeout) and
// presented on a valid/ready output.
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   bus       : sequenciador_operandos_if.master (ent_*, mult_*, sai_* handshakes)
//   ocupacao  : current FIFO entry count
//   acumulado : saturating running sum of accepted non-error results
//
// Parameters: PROF_FIFO (power of 2, >=2), TIMEOUT (>=8), LARG_ACUM.
// Optional feature: macro SEQUENCIADOR_ACUMULADOR_EN enables the accumulator;
// without it acumulado is tied to 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// OCIOSO  | waiting for a queued pair and an idle multiplier
// INICIA  | mult_st pulse, timeout counter cleared
// ESPERA  | waiting for mult_done or the timeout
// ENTREGA | result held on sai_* until sai_pronto
module sequenciador_operandos #(
    parameter int PROF_FIFO = 4,
    parameter int TIMEOUT   = 32,
    parameter int LARG_ACUM = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    sequenciador_operandos_if.master      bus,
    output logic [$clog2(PROF_FIFO):0]    ocupacao,
    output logic [LARG_ACUM-1:0]          acumulado
);
    localparam int LP = $clog2(PROF_FIFO);
    localparam int LC = $clog2(TIMEOUT);

    typedef enum logic [1:0] {OCIOSO, INICIA, ESPERA, ENTREGA} estado_t;

    estado_t        estado;
    estado_t        prox;

    logic [7:0]     mem [PROF_FIFO];
    logic [LP-1:0]  ptr_esc;
    logic [LP-1:0]  ptr_lei;
    logic [LP:0]    cont;
    logic           cheia;
    logic           vazia;
    logic           push;
    logic           pop;
    logic           captura;
    logic           expira;
    logic           aceite;

    logic [LC-1:0]  cnt_esp;
    logic [3:0]     op_a;
    logic [3:0]     op_b;
    logic [8:0]     prod_q;
    logic           erro_q;

    assign cheia   = (cont == (LP+1)'(PROF_FIFO));
    assign vazia   = (cont == '0);
    assign bus.ent_pronto = !cheia && !rst;
    assign push    = bus.ent_valido && bus.ent_pronto;
    assign pop     = (estado == OCIOSO) && !vazia && bus.mult_idle;
    assign captura = (estado == ESPERA) && bus.mult_done;
    // The counter starts at 0 on entering ESPERA; leaving on the cycle its next
    // value would be TIMEOUT-1 puts sai_valido exactly TIMEOUT cycles after st.
    assign expira  = (estado == ESPERA) && (cnt_esp == LC'(TIMEOUT-2));
    assign aceite  = (estado == ENTREGA) && bus.sai_pronto;

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (pop) prox = INICIA;
            INICIA:  prox = ESPERA;
            ESPERA:  if (captura || expira) prox = ENTREGA;
            ENTREGA: if (aceite) prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    // FIFO storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[ptr_esc] <= {bus.ent_multiplicando, bus.ent_multiplicador};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_esc <= '0;
            ptr_lei <= '0;
            cont    <= '0;
        end else begin
            if (push) ptr_esc <= ptr_esc + LP'(1);
            if (pop)  ptr_lei <= ptr_lei + LP'(1);
            case ({push, pop})
                2'b10:   cont <= cont + (LP+1)'(1);
                2'b01:   cont <= cont - (LP+1)'(1);
                default: cont <= cont;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            cnt_esp <= '0;
            prod_q  <= '0;
            erro_q  <= 1'b0;
        end else begin
            if (pop) {op_a, op_b} <= mem[ptr_lei];
            if (estado == INICIA)      cnt_esp <= '0;
            else if (estado == ESPERA) cnt_esp <= cnt_esp + LC'(1);
            // done has priority over a simultaneous timeout
            if (captura) begin
                prod_q <= bus.mult_produto;
                erro_q <= 1'b0;
            end else if (expira) begin
                prod_q <= '0;
                erro_q <= 1'b1;
            end
        end
    end

    assign bus.mult_multiplicando = op_a;
    assign bus.mult_multiplicador = op_b;
    assign bus.mult_st            = (estado == INICIA);
    assign bus.sai_valido         = (estado == ENTREGA);
    assign bus.sai_produto        = prod_q;
    assign bus.sai_erro           = erro_q;
    assign ocupacao               = cont;

`ifdef SEQUENCIADOR_ACUMULADOR_EN
    // One extra bit over the wider operand so the overflow is visible.
    localparam int LS = ((LARG_ACUM > 9) ? LARG_ACUM : 9) + 1;
    localparam logic [LS-1:0] MAX_ACUM = {{(LS-LARG_ACUM){1'b0}}, {LARG_ACUM{1'b1}}};

    logic [LARG_ACUM-1:0] acum_q;
    logic [LS-1:0]        soma;

    assign soma = LS'(acum_q) + LS'(prod_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            acum_q <= '0;
        end else if (aceite && !erro_q) begin
            acum_q <= (soma > MAX_ACUM) ? {LARG_ACUM{1'b1}} : soma[LARG_ACUM-1:0];
        end
    end

    assign acumulado = acum_q;
`else
    assign acumulado = '0;
`endif

endmodule

// File: tb/tb_sequenciador_operandos.sv
module tb_sequenciador_operandos;
    localparam int PROF_FIFO = 4;
    localparam int TIMEOUT   = 32;
    localparam int LARG_ACUM = 8;

    logic clk = 1'b0;
    logic rst;
    logic [$clog2(PROF_FIFO):0] ocupacao;
    logic [LARG_ACUM-1:0]       acumulado;

    sequenciador_operandos_if bus ();

    sequenciador_operandos #(
        .PROF_FIFO (PROF_FIFO),
        .TIMEOUT   (TIMEOUT),
        .LARG_ACUM (LARG_ACUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ocupacao  (ocupacao),
        .acumulado (acumulado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prod;
        bit erro;
        int lat;
    } res_t;

    // reference model: queued pairs, expected results, accumulator
    int   fila_a[$];
    int   fila_b[$];
    res_t fila_res[$];
    longint acc_ref = 0;

    int n_total = 0;
    int n_ok    = 0;
    int ciclo   = 0;
    int st_ciclo = 0;
    int st_total = 0;
    int st_esperado_em = -1;
    bit cand_st, ult_valido, ult_st, ult_aceito, idle_ant;

    // behavioural multiplier stub
    bit m_ocupado = 0;
    bit m_trava   = 0;
    bit m_op_trava = 0;
    bit modo_aleat = 0;
    int m_lat = 3, m_op_lat = 3, m_passos = 0, m_forca = 0, m_oa = 0, m_ob = 0;

    task automatic verificar(input string tag, input longint obs, input longint esp);
        n_total++;
        if (obs == esp) n_ok++;
        else $display("FAIL %s: obtido %0d, esperado %0d (ciclo %0d)", tag, obs, esp, ciclo);
    endtask

    function automatic longint acumular(input longint a, input longint p);
`ifdef SEQUENCIADOR_ACUMULADOR_EN
        longint lim = (longint'(1) << LARG_ACUM) - 1;
        return (a + p > lim) ? lim : a + p;
`else
        return 0;
`endif
    endfunction

    // One clock: observe the edge that just happened, check, step the stub.
    task automatic passo();
        res_t r;
        @(negedge clk);
        ciclo++;
        cand_st    = 0;
        ult_aceito = 0;
        if (rst) begin
            fila_a.delete();
            fila_b.delete();
            fila_res.delete();
            acc_ref = 0;
            st_esperado_em = -1;
        end else begin
            if (ult_valido && bus.sai_pronto && fila_res.size() > 0) begin
                if (!fila_res[0].erro) acc_ref = acumular(acc_ref, fila_res[0].prod);
                fila_res.delete(0);
                if (fila_a.size() > 0) cand_st = 1;
            end
            if (bus.ent_valido && fila_a.size() < PROF_FIFO) begin
                if (fila_a.size() == 0 && fila_res.size() == 0) cand_st = 1;
                fila_a.push_back(int'(bus.ent_multiplicando));
                fila_b.push_back(int'(bus.ent_multiplicador));
                ult_aceito = 1;
            end
        end

        if (bus.mult_st) begin
            st_total++;
            verificar("st_pulso", ult_st, 0);
            verificar("st_com_idle", idle_ant, 1);
            verificar("st_com_fila", fila_a.size(), (fila_a.size() > 0) ? fila_a.size() : 1);
            if (fila_a.size() > 0) begin
                if (modo_aleat) begin
                    m_lat   = $urandom_range(1, 8);
                    m_trava = ($urandom_range(0, 5) == 0);
                end
                verificar("op_a", bus.mult_multiplicando, fila_a[0]);
                verificar("op_b", bus.mult_multiplicador, fila_b[0]);
                m_oa = fila_a[0];
                m_ob = fila_b[0];
                m_op_trava = m_trava;
                m_op_lat   = m_lat;
                r.erro = m_trava || (m_lat >= TIMEOUT);
                r.prod = r.erro ? 0 : m_oa * m_ob;
                r.lat  = r.erro ? TIMEOUT : m_lat + 1;
                fila_res.push_back(r);
                fila_a.delete(0);
                fila_b.delete(0);
                st_ciclo = ciclo;
            end
        end
        if (st_esperado_em == ciclo) verificar("st_latencia", bus.mult_st, 1);
        if (st_esperado_em <= ciclo) st_esperado_em = -1;

        verificar("ocupacao", ocupacao, fila_a.size());
        verificar("ent_pronto", bus.ent_pronto, (!rst && fila_a.size() < PROF_FIFO));
        verificar("acumulado", acumulado, acc_ref);
        if (bus.sai_valido) begin
            if (fila_res.size() == 0) verificar("sai_sem_op", fila_res.size(), 1);
            else begin
                if (!ult_valido) verificar("sai_latencia", ciclo - st_ciclo, fila_res[0].lat);
                verificar("sai_produto", bus.sai_produto, fila_res[0].prod);
                verificar("sai_erro", bus.sai_erro, fila_res[0].erro);
            end
        end
        ult_valido = bus.sai_valido;
        ult_st     = bus.mult_st;

        bus.mult_done = 1'b0;
        if (m_forca > 0) begin
            m_forca--;
            m_ocupado = 0;
            bus.mult_idle = (m_forca == 0);
        end else if (m_ocupado) begin
            verificar("op_estavel", {bus.mult_multiplicando, bus.mult_multiplicador}, m_oa * 16 + m_ob);
            m_passos++;
            bus.mult_idle = 1'b0;
            if (m_passos == m_op_lat) begin
                bus.mult_done    = 1'b1;
                bus.mult_produto = 9'(m_oa * m_ob);
            end else if (m_passos > m_op_lat) begin
                m_ocupado = 0;
                bus.mult_idle = 1'b1;
            end
        end
        if (bus.mult_st && !m_op_trava && !m_ocupado) begin
            m_ocupado = 1;
            m_passos  = 0;
        end
        if (cand_st && bus.mult_idle) st_esperado_em = ciclo + 1;
        idle_ant = bus.mult_idle;
    endtask

    task automatic enviar(input int a, input int b);
        bus.ent_valido        = 1'b1;
        bus.ent_multiplicando = 4'(a);
        bus.ent_multiplicador = 4'(b);
        for (int i = 0; i < 60; i++) begin
            passo();
            if (ult_aceito) break;
        end
        verificar("enviar_aceito", ult_aceito, 1);
        bus.ent_valido = 1'b0;
    endtask

    task automatic esperar_vazio(input int limite, input bit pronto_aleat);
        bit ok = 0;
        for (int i = 0; i < limite; i++) begin
            if (pronto_aleat) bus.sai_pronto = 1'($urandom_range(0, 1));
            passo();
            if (fila_a.size() == 0 && fila_res.size() == 0 && !m_ocupado) begin
                ok = 1;
                break;
            end
        end
        verificar("esvaziar_limite", ok, 1);
    endtask

    task automatic verificar_reset();
        verificar("rst_mult_st", bus.mult_st, 0);
        verificar("rst_op_a", bus.mult_multiplicando, 0);
        verificar("rst_op_b", bus.mult_multiplicador, 0);
        verificar("rst_sai_valido", bus.sai_valido, 0);
        verificar("rst_sai_produto", bus.sai_produto, 0);
        verificar("rst_sai_erro", bus.sai_erro, 0);
        verificar("rst_ocupacao", ocupacao, 0);
        verificar("rst_ent_pronto", bus.ent_pronto, 0);
        verificar("rst_acumulado", acumulado, 0);
    endtask

    initial begin
        int c_rst;
        int st0;
        rst = 1'b1;
        bus.ent_valido = 1'b0;
        bus.ent_multiplicando = '0;
        bus.ent_multiplicador = '0;
        bus.mult_done = 1'b0;
        bus.mult_idle = 1'b1;
        bus.mult_produto = '0;
        bus.sai_pronto = 1'b0;
        idle_ant = 1'b1;

        passo();
        passo();
        verificar_reset();
        rst = 1'b0;
        passo();

        // single operation
        m_lat = 4;
        bus.sai_pronto = 1'b1;
        st0 = st_total;
        enviar(13, 11);
        esperar_vazio(200, 0);
        verificar("s1_st_unico", st_total - st0, 1);

        // back-to-back pairs with the output stalled, FIFO fills up
        m_lat = 2;
        bus.sai_pronto = 1'b0;
        enviar(13, 11);
        enviar(7, 15);
        enviar(15, 15);
        enviar(0, 9);
        enviar($urandom_range(0, 15), $urandom_range(0, 15));
        bus.ent_valido = 1'b1;
        bus.ent_multiplicando = 4'($urandom_range(0, 15));
        bus.ent_multiplicador = 4'($urandom_range(0, 15));
        repeat (100) passo();
        verificar("s2_cheia", ocupacao, PROF_FIFO);
        verificar("s2_pronto_baixo", bus.ent_pronto, 0);
        for (int i = 0; i < 100 && bus.ent_valido; i++) begin
            bus.sai_pronto = 1'($urandom_range(0, 1));
            passo();
            if (ult_aceito) bus.ent_valido = 1'b0;
        end
        verificar("s2_sexto_aceito", bus.ent_valido, 0);
        bus.ent_valido = 1'b0;
        esperar_vazio(400, 1);

        // timeout, then normal, then done on the last legal cycle, then one late
        bus.sai_pronto = 1'b1;
        m_trava = 1;
        enviar($urandom_range(0, 15), $urandom_range(0, 15));
        esperar_vazio(200, 0);
        m_trava = 0;
        m_lat = 3;
        enviar($urandom_range(0, 15), $urandom_range(0, 15));
        esperar_vazio(200, 0);
        m_lat = TIMEOUT - 1;
        enviar($urandom_range(1, 15), $urandom_range(1, 15));
        esperar_vazio(200, 0);
        m_lat = TIMEOUT;
        enviar($urandom_range(1, 15), $urandom_range(1, 15));
        esperar_vazio(200, 0);

        // reset during ESPERA while the multiplier stays busy
        m_lat = 20;
        enviar($urandom_range(0, 15), $urandom_range(0, 15));
        for (int i = 0; i < 50 && fila_res.size() == 0; i++) passo();
        verificar("s4_em_voo", fila_res.size(), 1);
        repeat (5) passo();
        c_rst = ciclo;
        rst = 1'b1;
        m_ocupado = 0;
        m_forca = 10;
        bus.mult_idle = 1'b0;
        passo();
        verificar_reset();
        rst = 1'b0;
        m_lat = 3;
        enviar($urandom_range(0, 15), $urandom_range(0, 15));
        esperar_vazio(200, 0);
        verificar("s4_st_apos_idle", st_ciclo - c_rst, 11);

        // random traffic
        modo_aleat = 1;
        for (int i = 0; i < 400; i++) begin
            bus.ent_valido = 1'($urandom_range(0, 1));
            bus.ent_multiplicando = 4'($urandom_range(0, 15));
            bus.ent_multiplicador = 4'($urandom_range(0, 15));
            bus.sai_pronto = 1'($urandom_range(0, 1));
            passo();
        end
        bus.ent_valido = 1'b0;
        esperar_vazio(1000, 1);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end
endmodule
